// File: rtl/stack_proc_pkg.sv
// Shared definitions for the stack-processor front end: default PC width,
// sequential fetch increment, branch offset width and sequencer states.
package stack_proc_pkg;

    localparam int PC_W_DEF = 16;
    localparam int PC_INC   = 2;
    localparam int BR_OFF_W = 13;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HALT   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-PC candidates: branch target (pc + sign-extended
// byte offset) and the sequential successor (pc + PC_INC). Both wrap
// modulo 2^PC_W. Assumes PC_W is wider than the branch offset.
module pc_target_adder
    import stack_proc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0]     i_pc,
    input  logic [BR_OFF_W-1:0] i_br_off,
    output logic [PC_W-1:0]     o_br_tgt,
    output logic [PC_W-1:0]     o_seq_pc
);

    logic [PC_W-1:0] w_off_ext;

    // Offset arrives already scaled to bytes; only sign extension is needed.
    assign w_off_ext = {{(PC_W-BR_OFF_W){i_br_off[BR_OFF_W-1]}}, i_br_off};
    assign o_br_tgt  = i_pc + w_off_ext;
    assign o_seq_pc  = i_pc + PC_W'(PC_INC);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN / BUBBLE / HALT control with one-cycle
// redirect bubble for taken branches and jumps, stall hold, and terminal halt.
// All outputs are registers, so there is no input-to-output path.
// Optional macro PC_MISALIGN_CHECK_EN: an odd jump target halts the sequencer
// and sets a sticky misalign flag; when undefined, bit 0 of the jump target
// is cleared and misalign is tied low.
module pc_sequencer
    import stack_proc_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                stall,
    input  logic                br_req,
    input  logic                br_cond,
    input  logic [BR_OFF_W-1:0] br_off,
    input  logic                jmp_req,
    input  logic [PC_W-1:0]     jmp_addr,
    input  logic                halt_req,
    output logic [PC_W-1:0]     pc,
    output logic                pc_valid,
    output logic                flush,
    output logic                halted,
    output logic                misalign
);

    seq_state_t      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_flush;
    logic            r_halted;

    logic [PC_W-1:0] w_br_tgt;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_jmp_tgt;
    logic            w_jmp_bad;
    logic            w_accept;

    pc_target_adder #(.PC_W(PC_W)) u_adder (
        .i_pc     (r_pc),
        .i_br_off (br_off),
        .o_br_tgt (w_br_tgt),
        .o_seq_pc (w_seq_pc)
    );

    // Decode requests are only honoured in a live, unstalled RUN cycle.
    assign w_accept = (r_state == ST_RUN) && r_pc_valid && !stall;

`ifdef PC_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_jmp_tgt = jmp_addr;
    assign w_jmp_bad = jmp_addr[0];
    assign misalign  = r_misalign;

    // Sticky error: an accepted odd jump (not pre-empted by halt) latches until reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_misalign <= 1'b0;
        else if (w_accept && !halt_req && jmp_req && w_jmp_bad)
            r_misalign <= 1'b1;
    end
`else
    logic w_unused_jmp_lsb;

    assign w_jmp_tgt        = {jmp_addr[PC_W-1:1], 1'b0};
    assign w_jmp_bad        = 1'b0;
    assign misalign         = 1'b0;
    assign w_unused_jmp_lsb = jmp_addr[0];
`endif

    // Sequencer FSM: state, PC and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!r_pc_valid) begin
                        // First edge out of reset: present RESET_PC as a real
                        // fetch; decode holds nothing yet, so requests are ignored.
                        r_pc_valid <= 1'b1;
                    end else if (!stall) begin
                        if (halt_req || (jmp_req && w_jmp_bad)) begin
                            r_state    <= ST_HALT;
                            r_pc_valid <= 1'b0;
                            r_halted   <= 1'b1;
                        end else if (jmp_req) begin
                            r_pc       <= w_jmp_tgt;
                            r_state    <= ST_BUBBLE;
                            r_pc_valid <= 1'b0;
                            r_flush    <= 1'b1;
                        end else if (br_req && br_cond) begin
                            r_pc       <= w_br_tgt;
                            r_state    <= ST_BUBBLE;
                            r_pc_valid <= 1'b0;
                            r_flush    <= 1'b1;
                        end else begin
                            r_pc <= w_seq_pc;
                        end
                    end
                end
                ST_BUBBLE: begin
                    // Redirect target becomes the live fetch; stall is ignored here.
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                    r_flush    <= 1'b0;
                end
                default: begin
                    // HALT is terminal until reset.
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign flush    = r_flush;
    assign halted   = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the stimulus process drives one decode
// cycle per negedge and pushes the reference model's expected outputs; the
// monitor pops and compares after every rising edge.
module tb_pc_sequencer;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        stall = 1'b0;
    logic        br_req = 1'b0;
    logic        br_cond = 1'b0;
    logic [12:0] br_off = '0;
    logic        jmp_req = 1'b0;
    logic [15:0] jmp_addr = '0;
    logic        halt_req = 1'b0;
    logic [15:0] pc;
    logic        pc_valid, flush, halted, misalign;

    pc_sequencer #(.PC_W(16), .RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RST(RST), .stall(stall), .br_req(br_req), .br_cond(br_cond),
        .br_off(br_off), .jmp_req(jmp_req), .jmp_addr(jmp_addr), .halt_req(halt_req),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .halted(halted), .misalign(misalign)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    logic [19:0] exp_q[$];
    string       name_q[$];

    // Reference model: architectural PC plus a few flags describing the cycle.
    logic [15:0] m_pc;
    bit          m_live, m_bubble, m_halt, m_mis;

    function automatic int sx13(input logic [12:0] v);
        return v[12] ? int'(v) - 8192 : int'(v);
    endfunction

    task automatic cmp(input string nm, input logic [19:0] got, input logic [19:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got pc=%h valid=%b flush=%b halted=%b misalign=%b, expected pc=%h valid=%b flush=%b halted=%b misalign=%b",
                     nm, got[19:4], got[3], got[2], got[1], got[0],
                     exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every rising edge presents a new output tuple.
    initial begin
        string nm;
        logic [19:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, {pc, pc_valid, flush, halted, misalign}, e);
            end
        end
    end

    // One decode cycle: drive inputs, advance the model, queue the expectation.
    task automatic step(input string nm, input bit s_st, input bit s_br, input bit s_cd,
                        input logic [12:0] s_off, input bit s_jm, input logic [15:0] s_ad,
                        input bit s_hl);
        stall = s_st; br_req = s_br; br_cond = s_cd; br_off = s_off;
        jmp_req = s_jm; jmp_addr = s_ad; halt_req = s_hl;
        if (m_halt) begin
            // terminal
        end else if (m_bubble) begin
            m_bubble = 0;
        end else if (!m_live) begin
            m_live = 1;
        end else if (s_st) begin
            // held
        end else if (s_hl) begin
            m_halt = 1;
        end else if (s_jm) begin
`ifdef PC_MISALIGN_CHECK_EN
            if (s_ad[0]) begin
                m_halt = 1;
                m_mis  = 1;
            end else begin
                m_pc     = s_ad;
                m_bubble = 1;
            end
`else
            m_pc     = s_ad & 16'hFFFE;
            m_bubble = 1;
`endif
        end else if (s_br && s_cd) begin
            m_pc     = 16'(int'(m_pc) + sx13(s_off));
            m_bubble = 1;
        end else begin
            m_pc = 16'(int'(m_pc) + 2);
        end
        exp_q.push_back({m_pc, m_live && !m_bubble && !m_halt, m_bubble, m_halt, m_mis});
        name_q.push_back(nm);
        @(negedge CLK);
    endtask

    task automatic idle(input string nm);
        step(nm, 0, 0, 0, 13'h0, 0, 16'h0, 0);
    endtask

    // Reset pulse starting at a negedge; checks the asynchronous reset values.
    task automatic rst_pulse(input string nm);
        RST = 1'b1;
        stall = 0; br_req = 0; br_cond = 0; br_off = '0;
        jmp_req = 0; jmp_addr = '0; halt_req = 0;
        #1;
        cmp({nm, "_async"}, {pc, pc_valid, flush, halted, misalign}, {RST_PC, 4'b0000});
        @(negedge CLK);
        @(negedge CLK);
        cmp({nm, "_held"}, {pc, pc_valid, flush, halted, misalign}, {RST_PC, 4'b0000});
        RST = 1'b0;
        m_pc = RST_PC; m_live = 0; m_bubble = 0; m_halt = 0; m_mis = 0;
    endtask

    initial begin
        int halt_cnt;
        @(negedge CLK);
        rst_pulse("por");
        idle("first_fetch");

        // Walk to 0x0010, then taken backward branch by -4.
        for (int i = 0; i < 8; i++) idle("seq");
        step("br_taken", 0, 1, 1, 13'h1FFC, 0, 16'h0, 0);
        step("br_bubble", 0, 0, 0, 13'h0, 1, 16'h0100, 0);
        idle("after_br");

        // Wrap with a not-taken branch at 0xFFFE.
        step("jmp_fffe", 0, 0, 0, 13'h0, 1, 16'hFFFE, 0);
        idle("jmp_bubble");
        step("wrap_nt", 0, 1, 0, 13'h0040, 0, 16'h0, 0);
        idle("after_wrap");

        // Jump beats branch; requests in the bubble are ignored.
        step("prio", 0, 1, 1, 13'h0010, 1, 16'h0400, 0);
        step("prio_bubble", 0, 1, 1, 13'h0020, 1, 16'h0800, 1);
        idle("after_prio");

        // Stall holds a pending jump, which is taken on release.
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 13'h0, 1, 16'h0200, 0);
        step("stall_rel", 0, 0, 0, 13'h0, 1, 16'h0200, 0);
        idle("stall_bubble");

        // Reset in the middle of a redirect bubble.
        step("jmp_pre_rst", 0, 0, 0, 13'h0, 1, 16'h0300, 0);
        rst_pulse("rst_bubble");
        idle("first_fetch2");
        idle("seq2");

        // Odd jump target.
        step("misalign", 0, 0, 0, 13'h0, 1, 16'h0401, 0);
        for (int i = 0; i < 3; i++) step("mis_after", 0, 1, 1, 13'h0008, 1, 16'h0100, 0);
        rst_pulse("rst_mis");
        idle("first_fetch3");

        // Halt wins over jump and is terminal.
        step("halt", 0, 0, 0, 13'h0, 1, 16'h0500, 1);
        for (int i = 0; i < 3; i++) step("halt_term", 0, 1, 1, 13'h0004, 1, 16'h0600, 0);
        rst_pulse("rst_halt");
        idle("first_fetch4");

        // Randomized traffic.
        halt_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra;
            logic [12:0] ro;
            ra = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ra[0] = 1'b0;
            ro = 13'($urandom) & 13'h1FFE;
            if (m_halt) halt_cnt++;
            if (halt_cnt > 3 || $urandom_range(0, 99) == 0) begin
                halt_cnt = 0;
                rst_pulse("rnd_rst");
            end
            step("rnd", $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, ro, $urandom_range(0, 7) == 0, ra,
                 $urandom_range(0, 39) == 0);
        end

        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
